// File: rtl/lu_sched_pkg.sv
// lu_sched_pkg: shared types and constants for the LU core scheduler.
// States, response codes and the element packing helper.
package lu_sched_pkg;

    localparam int MAT_BITS = 9;
    localparam int ELEM_W   = 3;
    localparam int LU_W     = MAT_BITS * ELEM_W;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        WAIT,
        COLLECT,
        RESP
    } state_t;

    typedef logic [1:0]          status_t;
    typedef logic [MAT_BITS-1:0] mat_t;
    typedef logic [ELEM_W-1:0]   elem_t;
    typedef logic [LU_W-1:0]     lu_vec_t;

    localparam status_t ST_OK   = 2'b00;
    localparam status_t ST_SING = 2'b01;
    localparam status_t ST_TMO  = 2'b10;
    localparam status_t ST_PERR = 2'b11;

    // Replace element k of a packed L or U vector.
    function automatic lu_vec_t put_elem(lu_vec_t v, int unsigned k, elem_t e);
        lu_vec_t r;
        r = v;
        r[ELEM_W*k +: ELEM_W] = e;
        return r;
    endfunction

endpackage

// File: rtl/lu_sched_if.sv
// lu_sched_if: requester and response channels of the LU scheduler.
// master = requester/consumer side, slave = scheduler side.
interface lu_sched_if #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
);
    import lu_sched_pkg::*;

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [MAT_BITS*NREQ-1:0] req_mat;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    status_t                  rsp_status;
    lu_vec_t                  rsp_l;
    lu_vec_t                  rsp_u;

    modport master (
        output req_valid, req_mat, rsp_ready,
        input  req_ready, rsp_valid, rsp_id,
        input  rsp_status, rsp_l, rsp_u
    );

    modport slave (
        input  req_valid, req_mat, rsp_ready,
        output req_ready, rsp_valid, rsp_id,
        output rsp_status, rsp_l, rsp_u
    );

endinterface

// File: rtl/lu_rr_arb.sv
// lu_rr_arb: combinational round-robin arbiter.
// Grants the first requester at or above ptr, wrapping.
module lu_rr_arb #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant
);

    logic found;

    // Scan offsets from the pointer; first active requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int o = 0; o < NREQ; o++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] &&
                    i == (int'(ptr) + o) % NREQ) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lu_sched.sv
// lu_sched: round-robin front end for a serial 3x3 binary LU core.
// Feeds one matrix at a time and returns a tagged L/U response.
module lu_sched
    import lu_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ID_W    = 1,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    lu_sched_if.slave        bus,
    output logic             core_in_valid,
    output logic             core_in_data,
    input  logic             core_out_valid,
    input  logic             core_invertible,
    input  logic [ELEM_W-1:0] core_out_l,
    input  logic [ELEM_W-1:0] core_out_u,
    output logic             core_flush,
    output logic             busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_n;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rdy;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] ptr_nxt;
    mat_t            gnt_mat;
    mat_t            mat_q;
    logic [3:0]      cnt_q;
    logic [TW-1:0]   tmo_q;
    logic [ID_W-1:0] id_q;
    status_t         st_q;
    lu_vec_t         l_q;
    lu_vec_t         u_q;
    logic            flush_q;
    logic            cnt_last;
    logic            tmo_hit;

    lu_rr_arb #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (gnt)
    );

    assign cnt_last = (cnt_q == 4'(MAT_BITS - 1));
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
    assign ptr_nxt  = (gnt_id == ID_W'(NREQ - 1)) ?
                      '0 : gnt_id + ID_W'(1);

    // Encode the one-hot grant into an index and select its matrix.
    always_comb begin
        gnt_id  = '0;
        gnt_mat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_id  = ID_W'(i);
                gnt_mat = bus.req_mat[MAT_BITS*i +: MAT_BITS];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and the combinational handshake/feed outputs.
    always_comb begin
        state_n       = state;
        rdy           = '0;
        core_in_valid = 1'b0;
        core_in_data  = 1'b0;
        unique case (state)
            IDLE: begin
                rdy = gnt;
                if (|gnt) state_n = FEED;
            end
            FEED: begin
                core_in_valid = 1'b1;
                core_in_data  = mat_q[cnt_q];
                if (cnt_last) state_n = WAIT;
            end
            WAIT: begin
                if (core_out_valid) begin
                    state_n = core_invertible ? COLLECT : RESP;
                end else if (tmo_hit) begin
                    state_n = RESP;
                end
            end
            COLLECT: begin
                if (!core_out_valid || cnt_last) state_n = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latch, counters, element capture and response status.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            mat_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            st_q    <= ST_OK;
            l_q     <= '0;
            u_q     <= '0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|gnt) begin
                        mat_q <= gnt_mat;
                        id_q  <= gnt_id;
                        ptr_q <= ptr_nxt;
                        cnt_q <= '0;
                        tmo_q <= '0;
                        st_q  <= ST_OK;
                        l_q   <= '0;
                        u_q   <= '0;
                    end
                end
                FEED: begin
                    cnt_q <= cnt_last ? 4'd0 : cnt_q + 4'd1;
                end
                WAIT: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (core_out_valid) begin
                        if (core_invertible) begin
                            l_q   <= put_elem(l_q, 0, core_out_l);
                            u_q   <= put_elem(u_q, 0, core_out_u);
                            cnt_q <= 4'd1;
                        end else begin
                            st_q <= ST_SING;
                        end
                    end else if (tmo_hit) begin
                        st_q    <= ST_TMO;
                        flush_q <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (core_out_valid) begin
                        l_q   <= put_elem(l_q, int'(cnt_q), core_out_l);
                        u_q   <= put_elem(u_q, int'(cnt_q), core_out_u);
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_last) st_q <= ST_OK;
                    end else begin
                        st_q <= ST_PERR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready  = rdy;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_status = st_q;
    assign bus.rsp_l      = l_q;
    assign bus.rsp_u      = u_q;
    assign core_flush     = flush_q;
    assign busy           = (state != IDLE);

endmodule
